fpu_div_iter: RTL and testbench

- Iterative single-precision IEEE-754 divider.
- Sits behind `fpu_exec` as the slave/responder end of the AXI-stream divide interface: operands and rounding mode in, quotient and 4-bit exception flags out.
- Full valid/ready handshake on both sides, so the consumer can apply backpressure.
- One operation in flight; restoring division producing BITS_PER_CYCLE quotient bits per cycle.

---
 rtl/fpu_div_iter_pkg.sv | 35 +++
 rtl/fpu_div_round.sv | 55 +++++
 rtl/fpu_div_iter.sv | 205 ++++++++++++++++++++
 tb/tb_fpu_div_iter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_div_iter_pkg.sv
// fpu_div_iter_pkg: shared types and constants for the iterative single-precision divider.
// Revision: 1.0
`default_nettype none

package fpu_div_iter_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_UNPACK = 3'd1,
      S_ITER   = 3'd2,
      S_ROUND  = 3'd3,
      S_DONE   = 3'd4
   } fpu_div_state_t;

   typedef enum logic [1:0] {
      RM_RN = 2'd0,
      RM_RZ = 2'd1,
      RM_RP = 2'd2,
      RM_RM = 2'd3
   } fpu_rm_t;

   typedef struct packed {
      logic divide_by_zero;
      logic invalid;
      logic overflow;
      logic underflow;
   } fpu_div_flags_t;

   localparam logic [31:0] FPU_QNAN    = 32'h7fff_ffff;
   localparam logic [30:0] FPU_INF_MAG = 31'h7f80_0000;
   localparam logic [30:0] FPU_MAX_MAG = 31'h7f7f_ffff;

endpackage

`default_nettype wire

// File: rtl/fpu_div_round.sv
// fpu_div_round: combinational rounding, exponent range check and packing of the raw quotient.
// Revision: 1.0
`default_nettype none

module fpu_div_round
   import fpu_div_iter_pkg::*;
(
   input  logic              i_sign,
   input  logic signed [9:0] i_exp,
   input  logic [25:0]       i_q,
   input  logic              i_sticky,
   input  fpu_rm_t           i_rm,
   output logic [31:0]       o_result,
   output logic              o_overflow,
   output logic              o_underflow
);

   logic              w_inexact;
   logic              w_inc;
   logic              w_to_inf;
   logic [24:0]       w_mant_r;
   logic [22:0]       w_frac;
   logic signed [9:0] w_exp;

   always_comb begin
      w_inexact = (|i_q[1:0]) | i_sticky;
      case (i_rm)
         RM_RN:   w_inc = i_q[1] & (i_q[0] | i_sticky | i_q[2]);
         RM_RZ:   w_inc = 1'b0;
         RM_RP:   w_inc = w_inexact & ~i_sign;
         default: w_inc = w_inexact & i_sign;
      endcase

      // i_q[25] is the hidden bit; a carry out of it renormalises by one place
      w_mant_r = {1'b0, i_q[25:2]} + {24'd0, w_inc};
      w_frac   = w_mant_r[24] ? w_mant_r[23:1] : w_mant_r[22:0];
      w_exp    = w_mant_r[24] ? (i_exp + 10'sd1) : i_exp;

      w_to_inf = (i_rm == RM_RN) | ((i_rm == RM_RP) & ~i_sign) | ((i_rm == RM_RM) & i_sign);

      o_overflow  = 1'b0;
      o_underflow = 1'b0;
      o_result    = {i_sign, w_exp[7:0], w_frac};
      if (w_exp >= 10'sd255) begin
         o_overflow = 1'b1;
         o_result   = {i_sign, (w_to_inf ? FPU_INF_MAG : FPU_MAX_MAG)};
      end else if (w_exp <= 10'sd0) begin
         o_underflow = 1'b1;
         o_result    = {i_sign, 31'd0};
      end
   end

endmodule

`default_nettype wire

// File: rtl/fpu_div_iter.sv
// fpu_div_iter: iterative IEEE-754 single-precision restoring divider with AXI-stream handshakes.
// Optional macro FPU_DIV_FIXED_LATENCY_EN: special cases take the full normal-path latency. Revision: 1.0
`default_nettype none

module fpu_div_iter
   import fpu_div_iter_pkg::*;
#(
   parameter int          BITS_PER_CYCLE = 1,
   parameter logic [31:0] QNAN           = FPU_QNAN
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] s_axis_a_tdata,
   input  logic [31:0] s_axis_b_tdata,
   input  logic [1:0]  s_axis_rm_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [31:0] m_axis_result_tdata,
   output logic [3:0]  m_axis_result_tuser,
   output logic        m_axis_result_tvalid,
   input  logic        m_axis_result_tready,
   output logic        busy
);

   localparam int         N_ITER   = 26 / BITS_PER_CYCLE;
   localparam logic [4:0] CNT_INIT = 5'(N_ITER - 1);

   fpu_div_state_t    r_state, w_next;
   logic [31:0]       r_a, r_b, r_res;
   fpu_rm_t           r_rm;
   logic              r_sign, r_special;
   logic signed [9:0] r_exp;
   logic [25:0]       r_rem, r_quo, w_rem_n, w_quo_n;
   logic [23:0]       r_div;
   logic [4:0]        r_cnt;
   fpu_div_flags_t    r_flags, w_spec_flags, w_rnd_flags;

   logic [7:0]  w_ea, w_eb;
   logic [23:0] w_ma, w_mb;
   logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
   logic        w_sign, w_lt, w_special;
   logic [31:0] w_spec_res, w_rnd_res;
   logic [9:0]  w_exp_un;
   logic        w_rnd_ov, w_rnd_uf;

   // Operand classification; a zero exponent field (zero or denormal) reads as zero
   always_comb begin
      w_ea     = r_a[30:23];
      w_eb     = r_b[30:23];
      w_ma     = {1'b1, r_a[22:0]};
      w_mb     = {1'b1, r_b[22:0]};
      w_a_nan  = (&w_ea) & (|r_a[22:0]);
      w_b_nan  = (&w_eb) & (|r_b[22:0]);
      w_a_inf  = (&w_ea) & ~(|r_a[22:0]);
      w_b_inf  = (&w_eb) & ~(|r_b[22:0]);
      w_a_zero = (w_ea == 8'd0);
      w_b_zero = (w_eb == 8'd0);
      w_sign   = r_a[31] ^ r_b[31];
      w_lt     = (w_ma < w_mb);
      w_exp_un = {2'b00, w_ea} - {2'b00, w_eb} + 10'd127 - {9'd0, w_lt};

      w_special    = 1'b1;
      w_spec_res   = QNAN;
      w_spec_flags = '0;
      if (w_a_nan | w_b_nan) begin
         w_spec_flags.invalid = (w_a_nan & ~r_a[22]) | (w_b_nan & ~r_b[22]);
      end else if ((w_a_inf & w_b_inf) | (w_a_zero & w_b_zero)) begin
         w_spec_flags.invalid = 1'b1;
      end else if (w_a_inf) begin
         w_spec_res = {w_sign, FPU_INF_MAG};
      end else if (w_b_inf) begin
         w_spec_res = {w_sign, 31'd0};
      end else if (w_b_zero) begin
         w_spec_res                  = {w_sign, FPU_INF_MAG};
         w_spec_flags.divide_by_zero = 1'b1;
      end else if (w_a_zero) begin
         w_spec_res = {w_sign, 31'd0};
      end else begin
         w_special = 1'b0;
      end
   end

   // Restoring division steps retired this cycle
   always_comb begin
      w_rem_n = r_rem;
      w_quo_n = r_quo;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (w_rem_n >= {2'b00, r_div}) begin
            w_rem_n = w_rem_n - {2'b00, r_div};
            w_quo_n = {w_quo_n[24:0], 1'b1};
         end else begin
            w_quo_n = {w_quo_n[24:0], 1'b0};
         end
         w_rem_n = {w_rem_n[24:0], 1'b0};
      end
   end

   fpu_div_round u_round (
      .i_sign      (r_sign),
      .i_exp       (r_exp),
      .i_q         (r_quo),
      .i_sticky    (r_rem != 26'd0),
      .i_rm        (r_rm),
      .o_result    (w_rnd_res),
      .o_overflow  (w_rnd_ov),
      .o_underflow (w_rnd_uf)
   );

   always_comb begin
      w_rnd_flags           = '0;
      w_rnd_flags.overflow  = w_rnd_ov;
      w_rnd_flags.underflow = w_rnd_uf;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (s_axis_tvalid) w_next = S_UNPACK;
`ifdef FPU_DIV_FIXED_LATENCY_EN
         S_UNPACK: w_next = S_ITER;
`else
         S_UNPACK: w_next = w_special ? S_DONE : S_ITER;
`endif
         S_ITER:   if (r_cnt == 5'd0) w_next = S_ROUND;
         S_ROUND:  w_next = S_DONE;
         S_DONE:   if (m_axis_result_tready) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
      if (flush) w_next = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a       <= '0;
         r_b       <= '0;
         r_rm      <= RM_RN;
         r_sign    <= 1'b0;
         r_special <= 1'b0;
         r_exp     <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_div     <= '0;
         r_cnt     <= '0;
         r_res     <= '0;
         r_flags   <= '0;
      end else if (flush) begin
         r_res     <= '0;
         r_flags   <= '0;
         r_special <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (s_axis_tvalid) begin
                  r_a  <= s_axis_a_tdata;
                  r_b  <= s_axis_b_tdata;
                  r_rm <= fpu_rm_t'(s_axis_rm_tdata);
               end
            end
            S_UNPACK: begin
               r_sign    <= w_sign;
               r_cnt     <= CNT_INIT;
               r_quo     <= '0;
               r_special <= w_special;
               r_div     <= w_mb;
               r_exp     <= w_exp_un;
               if (w_special) begin
                  r_res   <= w_spec_res;
                  r_flags <= w_spec_flags;
                  r_rem   <= '0;
               end else begin
                  // Pre-normalise so the first quotient bit is always the hidden 1
                  r_rem <= w_lt ? {1'b0, w_ma, 1'b0} : {2'b00, w_ma};
               end
            end
            S_ITER: begin
               r_rem <= w_rem_n;
               r_quo <= w_quo_n;
               r_cnt <= r_cnt - 5'd1;
            end
            S_ROUND: begin
               if (!r_special) begin
                  r_res   <= w_rnd_res;
                  r_flags <= w_rnd_flags;
               end
            end
            default: ;
         endcase
      end
   end

   assign s_axis_tready        = (r_state == S_IDLE) && !flush;
   assign m_axis_result_tvalid = (r_state == S_DONE);
   assign m_axis_result_tdata  = r_res;
   assign m_axis_result_tuser  = r_flags;
   assign busy                 = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fpu_div_iter.sv
// tb_fpu_div_iter: directed vectors for fpu_div_iter, checked by a queue-based scoreboard/monitor.
// Revision: 1.0
`default_nettype none

module tb_fpu_div_iter;

   localparam int NORM_LAT = 28;
`ifdef FPU_DIV_FIXED_LATENCY_EN
   localparam int SPEC_LAT = 28;
`else
   localparam int SPEC_LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic [1:0]  rm = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] res_data;
   logic [3:0]  res_user;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc   = 0;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  user;
      int          lat;
      int          acc;
   } exp_t;
   exp_t sbq[$];

   fpu_div_iter dut (
      .clk                  (clk),
      .rst                  (rst),
      .flush                (flush),
      .s_axis_a_tdata       (a),
      .s_axis_b_tdata       (b),
      .s_axis_rm_tdata      (rm),
      .s_axis_tvalid        (in_valid),
      .s_axis_tready        (in_ready),
      .m_axis_result_tdata  (res_data),
      .m_axis_result_tuser  (res_user),
      .m_axis_result_tvalid (res_valid),
      .m_axis_result_tready (res_ready),
      .busy                 (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: compares each newly presented result against the scoreboard head
   initial begin
      bit   seen;
      exp_t e;
      seen = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (res_valid && !seen) begin
            seen = 1'b1;
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_result: got %h expected none", res_data);
            end else begin
               e = sbq.pop_front();
               chk("tdata", res_data, e.data);
               chk("tuser", {28'd0, res_user}, {28'd0, e.user});
               chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
         end else if (!res_valid) begin
            seen = 1'b0;
         end
      end
   end

   task automatic accept(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] trm);
      int n = 0;
      a = ta; b = tb; rm = trm; in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 100) begin
         total++; bad++;
         $display("FAIL accept_timeout: got tready=0 expected 1");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      acc = cyc;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!res_valid && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 100) begin
         total++; bad++;
         $display("FAIL result_timeout: got tvalid=0 expected 1");
      end
   endtask

   task automatic run(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] trm,
                      input logic [31:0] ed, input logic [3:0] eu, input int lat);
      accept(ta, tb, trm);
      sbq.push_back('{ed, eu, lat, acc});
      wait_valid();
      @(posedge clk); #1;
   endtask

   task automatic quiet_window(input string nm);
      bit rose = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (res_valid) rose = 1'b1;
      end
      chk(nm, {31'd0, rose}, 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tready", {31'd0, in_ready}, 32'd1);
      chk("rst_tvalid", {31'd0, res_valid}, 32'd0);
      chk("rst_tdata", res_data, 32'd0);
      chk("rst_tuser", {28'd0, res_user}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run(32'h3f800000, 32'h40400000, 2'd0, 32'h3eaaaaab, 4'b0000, NORM_LAT);
      run(32'h3f800000, 32'h40400000, 2'd1, 32'h3eaaaaaa, 4'b0000, NORM_LAT);
      run(32'h3f800000, 32'h40400000, 2'd2, 32'h3eaaaaab, 4'b0000, NORM_LAT);
      run(32'hbf800000, 32'h40400000, 2'd3, 32'hbeaaaaab, 4'b0000, NORM_LAT);
      run(32'hbf800000, 32'h40400000, 2'd2, 32'hbeaaaaaa, 4'b0000, NORM_LAT);
      run(32'h3f800000, 32'h00000000, 2'd0, 32'h7f800000, 4'b1000, SPEC_LAT);
      run(32'h00000000, 32'h00000000, 2'd0, 32'h7fffffff, 4'b0100, SPEC_LAT);
      run(32'h7fa00000, 32'h3f800000, 2'd0, 32'h7fffffff, 4'b0100, SPEC_LAT);
      run(32'h7fc00000, 32'h3f800000, 2'd0, 32'h7fffffff, 4'b0000, SPEC_LAT);
      run(32'h7f800000, 32'h80000000, 2'd0, 32'hff800000, 4'b0000, SPEC_LAT);
      run(32'h3f800000, 32'hff800000, 2'd0, 32'h80000000, 4'b0000, SPEC_LAT);
      run(32'h7f7fffff, 32'h3f000000, 2'd0, 32'h7f800000, 4'b0010, NORM_LAT);
      run(32'h7f7fffff, 32'h3f000000, 2'd1, 32'h7f7fffff, 4'b0010, NORM_LAT);
      run(32'h7f7fffff, 32'h3f000000, 2'd2, 32'h7f800000, 4'b0010, NORM_LAT);
      run(32'h7f7fffff, 32'h3f000000, 2'd3, 32'h7f7fffff, 4'b0010, NORM_LAT);
      run(32'h00800000, 32'h40000000, 2'd0, 32'h00000000, 4'b0001, NORM_LAT);
      run(32'h40800000, 32'h40000000, 2'd0, 32'h40000000, 4'b0000, NORM_LAT);

      // Backpressure: result must hold while the consumer stalls
      res_ready = 1'b0;
      accept(32'h3f800000, 32'h40400000, 2'd0);
      sbq.push_back('{32'h3eaaaaab, 4'b0000, NORM_LAT, acc});
      wait_valid();
      repeat (10) begin
         @(posedge clk); #1;
         chk("bp_tdata", res_data, 32'h3eaaaaab);
         chk("bp_tvalid", {31'd0, res_valid}, 32'd1);
         chk("bp_tready", {31'd0, in_ready}, 32'd0);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_tvalid", {31'd0, res_valid}, 32'd0);
      chk("bp_release_tready", {31'd0, in_ready}, 32'd1);
      chk("bp_release_busy", {31'd0, busy}, 32'd0);

      // Flush during ITER discards the operation
      accept(32'h3f800000, 32'h40400000, 2'd0);
      repeat (5) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      #1;
      chk("flush_blocks_tready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      #1;
      chk("flush_tvalid", {31'd0, res_valid}, 32'd0);
      chk("flush_tready", {31'd0, in_ready}, 32'd1);
      chk("flush_busy", {31'd0, busy}, 32'd0);
      quiet_window("flush_no_result");
      run(32'h40800000, 32'h40000000, 2'd0, 32'h40000000, 4'b0000, NORM_LAT);

      // Asynchronous reset mid-operation
      accept(32'h3f800000, 32'h40400000, 2'd0);
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      chk("arst_tready", {31'd0, in_ready}, 32'd1);
      chk("arst_tvalid", {31'd0, res_valid}, 32'd0);
      chk("arst_tdata", res_data, 32'd0);
      chk("arst_tuser", {28'd0, res_user}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      quiet_window("arst_no_result");
      run(32'h3f800000, 32'h40400000, 2'd1, 32'h3eaaaaaa, 4'b0000, NORM_LAT);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
